acc_regfile_param: RTL and testbench
====================================

Name: acc_regfile_param

Overview:
Parametrised successor to the 3-bit-addressed, 8-bit, dual-read accumulator bank in the decode stage. Holds NUM_ACC accumulators of WIDTH bits with two combinational read ports and one write port. Writes can load, add, subtract or clear, with optional saturation. Each entry carries a sticky overflow flag. A sequenced sweep-clear engine zeroes the bank one entry per cycle. Sits between decode and execute; feeds operands to the ALU and takes results back.

Parameters:
NUM_ACC, 8, number of accumulators (2..256)
WIDTH, 8, accumulator data width in bits
SATURATE, 0, 1 = ADD/SUB clamp on overflow; 0 = wrap modulo 2^WIDTH
AW (localparam), $clog2(NUM_ACC), address width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
read1  input  AW  read port 1 address
read2  input  AW  read port 2 address
isWrite  input  1  write request this cycle
wrMode  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
writeReg  input  AW  write target address
writeData  input  WIDTH  write operand
clearReq  input  1  start sweep-clear of whole bank
acc1  output  WIDTH  data at read1
acc2  output  WIDTH  data at read2
ovf1  output  1  sticky overflow flag of read1
busy  output  1  sweep-clear in progress

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RST_N).
- Reset: all accumulators = 0, all flags = 0, FSM = IDLE, sweep pointer = 0, busy = 0. Reset asserted mid-sweep aborts the sweep immediately; the bank is all zero after reset.
- Reads are combinational from storage, zero latency.
- Address >= NUM_ACC (only possible when NUM_ACC is not a power of 2): read returns 0 and ovf1 = 0; write is dropped.
- Write result, computed from the current stored value acc[writeReg]:
  - LOAD: result = writeData; flag cleared.
  - ADD: WIDTH+1-bit sum. On carry-out, flag is set (sticky). Result = 2^WIDTH-1 if SATURATE, else low WIDTH bits.
  - SUB: acc - writeData. On borrow, flag is set (sticky). Result = 0 if SATURATE, else low WIDTH bits.
  - CLR: result = 0; flag cleared.
  - A non-overflowing ADD/SUB leaves the flag unchanged.
- Commit: an accepted write updates storage and flag on the next rising edge.
- Bypass: when isWrite=1, busy=0, the address is valid and readN == writeReg, accN (and ovf1 for port 1) show the same-cycle result and new flag, not the stored value. Both ports may bypass at once.
- Sweep-clear FSM:
  - IDLE: busy = 0. clearReq=1 sampled at an edge -> CLEAR, pointer = 0. A write in that same cycle is still accepted and committed.
  - CLEAR: busy = 1. Each edge zeroes acc[pointer] and its flag, then increments the pointer. On the edge with pointer = NUM_ACC-1 -> IDLE.
  - The sweep takes exactly NUM_ACC cycles with busy high.
- While busy:
  - isWrite is ignored; the write is dropped, with no retry.
  - clearReq is ignored.
  - Bypass is disabled.
  - Reads return storage, so entries not yet swept still show old values.
- Simultaneous isWrite and clearReq in IDLE: the write commits, the sweep starts, and the written entry is later cleared by the sweep.

Decomposition:
- Shared package acc_pkg:
  - typedef enum logic[1:0] wr_mode_t {WR_LOAD, WR_ADD, WR_SUB, WR_CLR}
  - typedef enum logic clr_state_t {CLR_IDLE, CLR_SWEEP}
- Sub-module acc_alu: combinational (old value, operand, mode, SATURATE) -> (result, set_flag, clear_flag).
- Its single output drives both the commit path and the bypass mux, guaranteeing the two never diverge.

Test Plan:
- Reset then read all addresses -> every accN = 0, ovf1 = 0, busy = 0; assert RST_N low mid-sweep -> busy drops asynchronously and all entries read 0.
- LOAD r3 = 0xF0, then ADD r3 += 0x20 (WIDTH = 8, SATURATE = 0) -> r3 = 0x10, ovf1 = 1 at read1 = 3. Next, ADD 0x01 -> r3 = 0x11 and ovf1 stays 1. Next, LOAD -> ovf1 = 0.
- SATURATE = 1: r2 = 0x05, SUB 0x09 -> r2 = 0x00, flag set. r2 = 0xFE, ADD 0x05 -> r2 = 0xFF.
- Bypass: in one cycle, isWrite LOAD r1 = 0x5A with read1 = read2 = 1 -> acc1 = acc2 = 0x5A that cycle; storage shows 0x5A after the edge.
- clearReq with all entries = 0xAA (NUM_ACC = 8) -> busy high for exactly 8 cycles, entries zero in index order; a write issued during busy is dropped (entry reads 0 after the sweep); a second clearReq during busy does not extend the sweep.
- NUM_ACC = 6: write to address 7 -> no entry changes; read1 = 7 -> acc1 = 0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the parametrised accumulator bank: write opcodes and
// sweep-clear sequencer states.
package acc_pkg;

    typedef enum logic [1:0] {
        WR_LOAD = 2'b00,
        WR_ADD  = 2'b01,
        WR_SUB  = 2'b10,
        WR_CLR  = 2'b11
    } wr_mode_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/acc_alu.sv
// Write-result datapath for one accumulator entry: load/add/sub/clear with
// carry/borrow detection and optional saturation.
module acc_alu
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] operand,
    input  wr_mode_t         mode,
    output logic [WIDTH-1:0] result,
    output logic             set_flag,
    output logic             clear_flag
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum        = {1'b0, old_val} + {1'b0, operand};
        diff       = {1'b0, old_val} - {1'b0, operand};
        result     = '0;
        set_flag   = 1'b0;
        clear_flag = 1'b0;
        unique case (mode)
            WR_LOAD: begin
                result     = operand;
                clear_flag = 1'b1;
            end
            WR_ADD: begin
                set_flag = sum[WIDTH];
                result   = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            // diff[WIDTH] is the borrow out of the unsigned subtraction
            WR_SUB: begin
                set_flag = diff[WIDTH];
                result   = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            WR_CLR: begin
                clear_flag = 1'b1;
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/acc_regfile_param.sv
// Parametrised accumulator bank: two combinational read ports with write
// bypass, one read-modify-write port, sticky overflow flags, sweep-clear.
module acc_regfile_param
    import acc_pkg::*;
#(
    parameter  int unsigned NUM_ACC  = 8,
    parameter  int unsigned WIDTH    = 8,
    parameter  bit          SATURATE = 1'b0,
    localparam int unsigned AW       = $clog2(NUM_ACC)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AW-1:0]    read1,
    input  logic [AW-1:0]    read2,
    input  logic             isWrite,
    input  logic [1:0]       wrMode,
    input  logic [AW-1:0]    writeReg,
    input  logic [WIDTH-1:0] writeData,
    input  logic             clearReq,
    output logic [WIDTH-1:0] acc1,
    output logic [WIDTH-1:0] acc2,
    output logic             ovf1,
    output logic             busy
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_ACC - 1);

    logic [WIDTH-1:0] acc_q  [NUM_ACC];
    logic [WIDTH-1:0] acc_d  [NUM_ACC];
    logic             flag_q [NUM_ACC];
    logic             flag_d [NUM_ACC];

    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic             rd1_valid, rd2_valid, wr_valid;
    logic             wr_en, byp1, byp2;
    logic [WIDTH-1:0] wr_old;
    logic             wr_old_flag;
    logic [WIDTH-1:0] alu_result;
    logic             alu_set, alu_clr;
    logic             new_flag;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) < NUM_ACC;
    endfunction

    // Write qualification and operand fetch
    always_comb begin
        rd1_valid   = addr_ok(read1);
        rd2_valid   = addr_ok(read2);
        wr_valid    = addr_ok(writeReg);
        wr_en       = isWrite && (state_q == CLR_IDLE) && wr_valid;
        wr_old      = wr_valid ? acc_q[writeReg] : '0;
        wr_old_flag = wr_valid ? flag_q[writeReg] : 1'b0;
        new_flag    = alu_set ? 1'b1 : (alu_clr ? 1'b0 : wr_old_flag);
        byp1        = wr_en && (read1 == writeReg);
        byp2        = wr_en && (read2 == writeReg);
    end

    // One ALU feeds both commit and bypass, so they cannot disagree
    acc_alu #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .old_val    (wr_old),
        .operand    (writeData),
        .mode       (wr_mode_t'(wrMode)),
        .result     (alu_result),
        .set_flag   (alu_set),
        .clear_flag (alu_clr)
    );

    always_comb begin
        acc1 = '0;
        acc2 = '0;
        ovf1 = 1'b0;
        if (byp1) begin
            acc1 = alu_result;
            ovf1 = new_flag;
        end else if (rd1_valid) begin
            acc1 = acc_q[read1];
            ovf1 = flag_q[read1];
        end
        if (byp2) begin
            acc2 = alu_result;
        end else if (rd2_valid) begin
            acc2 = acc_q[read2];
        end
    end

    // Writes are only accepted while idle, so they never collide with the sweep
    always_comb begin
        acc_d  = acc_q;
        flag_d = flag_q;
        if (wr_en) begin
            acc_d[writeReg]  = alu_result;
            flag_d[writeReg] = new_flag;
        end
        if (state_q == CLR_SWEEP) begin
            acc_d[ptr_q]  = '0;
            flag_d[ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q  <= '{default: '0};
            flag_q <= '{default: 1'b0};
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clearReq) begin
                    state_d = CLR_SWEEP;
                    ptr_d   = '0;
                end
            end
            CLR_SWEEP: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = CLR_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = CLR_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == CLR_SWEEP);
    end

endmodule

// File: tb/tb_acc_regfile_param.sv
// Bench for acc_regfile_param: three configurations (8/wrap, 8/saturate,
// 6/wrap) share one stimulus stream and are each checked against a model.
module tb_acc_regfile_param;

    logic       CLK;
    logic       RST_N;
    logic [2:0] read1, read2, writeReg;
    logic       isWrite, clearReq;
    logic [1:0] wrMode;
    logic [7:0] writeData;

    logic [7:0] acc1_o [3];
    logic [7:0] acc2_o [3];
    logic       ovf1_o [3];
    logic       busy_o [3];

    logic [7:0] s_acc1 [3];
    logic [7:0] s_acc2 [3];
    logic       s_ovf1 [3];
    logic       s_busy [3];

    int unsigned tests  = 0;
    int unsigned failed = 0;

    // Model state
    int unsigned       m_acc  [3][8];
    bit                m_flg  [3][8];
    bit                m_busy [3];
    int unsigned       m_ptr  [3];
    const int unsigned M_N   [3] = '{8, 8, 6};
    const bit          M_SAT [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int unsigned r1, r2, we, mode, wa, wd;
        int unsigned e1, e2, eo, es1, eso;
    } vec_t;

    vec_t tbl [18];

    acc_regfile_param #(.NUM_ACC(8), .WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .read1(read1), .read2(read2), .isWrite(isWrite),
        .wrMode(wrMode), .writeReg(writeReg), .writeData(writeData), .clearReq(clearReq),
        .acc1(acc1_o[0]), .acc2(acc2_o[0]), .ovf1(ovf1_o[0]), .busy(busy_o[0]));

    acc_regfile_param #(.NUM_ACC(8), .WIDTH(8), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .read1(read1), .read2(read2), .isWrite(isWrite),
        .wrMode(wrMode), .writeReg(writeReg), .writeData(writeData), .clearReq(clearReq),
        .acc1(acc1_o[1]), .acc2(acc2_o[1]), .ovf1(ovf1_o[1]), .busy(busy_o[1]));

    acc_regfile_param #(.NUM_ACC(6), .WIDTH(8), .SATURATE(1'b0)) u_odd (
        .CLK(CLK), .RST_N(RST_N), .read1(read1), .read2(read2), .isWrite(isWrite),
        .wrMode(wrMode), .writeReg(writeReg), .writeData(writeData), .clearReq(clearReq),
        .acc1(acc1_o[2]), .acc2(acc2_o[2]), .ovf1(ovf1_o[2]), .busy(busy_o[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 8; a++) begin
                m_acc[k][a] = 0;
                m_flg[k][a] = 1'b0;
            end
            m_busy[k] = 1'b0;
            m_ptr[k]  = 0;
        end
    endfunction

    // Result of the current write request applied to (old, oldf)
    function automatic void model_write(input int k, input int unsigned old, input bit oldf,
                                        output int unsigned res, output bit f);
        int unsigned d;
        d = writeData;
        f = oldf;
        res = old;
        case (wrMode)
            2'd0: begin res = d; f = 1'b0; end
            2'd1: begin
                res = old + d;
                if (res > 255) begin
                    f   = 1'b1;
                    res = M_SAT[k] ? 255 : res - 256;
                end
            end
            2'd2: begin
                if (d > old) begin
                    f   = 1'b1;
                    res = M_SAT[k] ? 0 : old + 256 - d;
                end else begin
                    res = old - d;
                end
            end
            default: begin res = 0; f = 1'b0; end
        endcase
    endfunction

    function automatic void model_read(input int k, input int unsigned a,
                                       output int unsigned v, output bit f);
        if (a >= M_N[k]) begin
            v = 0;
            f = 1'b0;
        end else if (!m_busy[k] && isWrite && (writeReg < M_N[k]) && (a == writeReg)) begin
            model_write(k, m_acc[k][a], m_flg[k][a], v, f);
        end else begin
            v = m_acc[k][a];
            f = m_flg[k][a];
        end
    endfunction

    function automatic void model_edge(input int k);
        int unsigned r;
        bit          f;
        if (m_busy[k]) begin
            m_acc[k][m_ptr[k]] = 0;
            m_flg[k][m_ptr[k]] = 1'b0;
            if (m_ptr[k] == M_N[k] - 1) m_busy[k] = 1'b0;
            else m_ptr[k] = m_ptr[k] + 1;
        end else begin
            if (isWrite && (writeReg < M_N[k])) begin
                model_write(k, m_acc[k][writeReg], m_flg[k][writeReg], r, f);
                m_acc[k][writeReg] = r;
                m_flg[k][writeReg] = f;
            end
            if (clearReq) begin
                m_busy[k] = 1'b1;
                m_ptr[k]  = 0;
            end
        end
    endfunction

    // Called at posedge+1: check all outputs at the falling edge, then advance
    task automatic cycle();
        int unsigned e1, e2;
        bit          f1, f2;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            model_read(k, read1, e1, f1);
            model_read(k, read2, e2, f2);
            chk($sformatf("acc1[%0d]", k), 32'(acc1_o[k]), e1);
            chk($sformatf("acc2[%0d]", k), 32'(acc2_o[k]), e2);
            chk($sformatf("ovf1[%0d]", k), 32'(ovf1_o[k]), 32'(f1));
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_busy[k]));
        end
        s_acc1 = acc1_o;
        s_acc2 = acc2_o;
        s_ovf1 = ovf1_o;
        s_busy = busy_o;
        for (int k = 0; k < 3; k++) model_edge(k);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        isWrite   = 1'b0;
        clearReq  = 1'b0;
        wrMode    = 2'd0;
        writeReg  = 3'd0;
        writeData = 8'd0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            read1 = 3'(a);
            read2 = 3'(a);
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s_acc1[%0d][%0d]", tag, k, a), 32'(acc1_o[k]), 0);
                chk($sformatf("%s_acc2[%0d][%0d]", tag, k, a), 32'(acc2_o[k]), 0);
                chk($sformatf("%s_ovf1[%0d][%0d]", tag, k, a), 32'(ovf1_o[k]), 0);
            end
        end
    endtask

    initial begin
        int unsigned busy_cycles;

        // r1 r2 we mode wa wd | e1 e2 eo | sat e1, sat ovf
        tbl[0]  = '{3, 3, 1, 0, 3, 'hF0, 'hF0, 'hF0, 0, 'hF0, 0};
        tbl[1]  = '{3, 3, 1, 1, 3, 'h20, 'h10, 'h10, 1, 'hFF, 1};
        tbl[2]  = '{3, 0, 0, 0, 0, 'h00, 'h10, 'h00, 1, 'hFF, 1};
        tbl[3]  = '{3, 3, 1, 1, 3, 'h01, 'h11, 'h11, 1, 'hFF, 1};
        tbl[4]  = '{3, 0, 0, 0, 0, 'h00, 'h11, 'h00, 1, 'hFF, 1};
        tbl[5]  = '{3, 3, 1, 0, 3, 'h33, 'h33, 'h33, 0, 'h33, 0};
        tbl[6]  = '{3, 3, 0, 0, 0, 'h00, 'h33, 'h33, 0, 'h33, 0};
        tbl[7]  = '{1, 1, 1, 0, 1, 'h5A, 'h5A, 'h5A, 0, 'h5A, 0};
        tbl[8]  = '{1, 3, 0, 0, 0, 'h00, 'h5A, 'h33, 0, 'h5A, 0};
        tbl[9]  = '{1, 0, 1, 2, 1, 'h5B, 'hFF, 'h00, 1, 'h00, 1};
        tbl[10] = '{1, 3, 1, 3, 1, 'h77, 'h00, 'h33, 0, 'h00, 0};
        tbl[11] = '{1, 1, 0, 0, 0, 'h00, 'h00, 'h00, 0, 'h00, 0};
        tbl[12] = '{2, 2, 1, 0, 2, 'h05, 'h05, 'h05, 0, 'h05, 0};
        tbl[13] = '{2, 2, 1, 2, 2, 'h09, 'hFC, 'hFC, 1, 'h00, 1};
        tbl[14] = '{2, 3, 0, 0, 0, 'h00, 'hFC, 'h33, 1, 'h00, 1};
        tbl[15] = '{2, 2, 1, 0, 2, 'hFE, 'hFE, 'hFE, 0, 'hFE, 0};
        tbl[16] = '{2, 2, 1, 1, 2, 'h05, 'h03, 'h03, 1, 'hFF, 1};
        tbl[17] = '{2, 2, 0, 0, 0, 'h00, 'h03, 'h03, 1, 'hFF, 1};

        RST_N = 1'b0;
        read1 = 3'd0;
        read2 = 3'd0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("rst_busy[%0d]", k), 32'(busy_o[k]), 0);
        check_all_zero("rst");
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vectors: wrap/saturate arithmetic, sticky flags, bypass
        foreach (tbl[i]) begin
            read1     = 3'(tbl[i].r1);
            read2     = 3'(tbl[i].r2);
            isWrite   = (tbl[i].we != 0);
            wrMode    = 2'(tbl[i].mode);
            writeReg  = 3'(tbl[i].wa);
            writeData = 8'(tbl[i].wd);
            clearReq  = 1'b0;
            cycle();
            chk($sformatf("vec%0d_acc1", i), 32'(s_acc1[0]), tbl[i].e1);
            chk($sformatf("vec%0d_acc2", i), 32'(s_acc2[0]), tbl[i].e2);
            chk($sformatf("vec%0d_ovf1", i), 32'(s_ovf1[0]), tbl[i].eo);
            chk($sformatf("vec%0d_sat_acc1", i), 32'(s_acc1[1]), tbl[i].es1);
            chk($sformatf("vec%0d_sat_ovf1", i), 32'(s_ovf1[1]), tbl[i].eso);
        end

        // Out-of-range address on the 6-entry bank
        read1 = 3'd7; read2 = 3'd5; isWrite = 1'b1; wrMode = 2'd0;
        writeReg = 3'd7; writeData = 8'h77; clearReq = 1'b0;
        cycle();
        chk("oor_bypass_wrap", 32'(s_acc1[0]), 'h77);
        chk("oor_read_odd", 32'(s_acc1[2]), 0);
        idle_inputs();
        cycle();
        chk("oor_after_odd", 32'(s_acc1[2]), 0);

        // Fill bank with 0xAA, then sweep with a dropped write and a second clearReq
        for (int a = 0; a < 8; a++) begin
            isWrite = 1'b1; wrMode = 2'd0; writeReg = 3'(a); writeData = 8'hAA;
            read1 = 3'(a); read2 = 3'(a);
            cycle();
        end
        idle_inputs();
        clearReq = 1'b1;
        cycle();
        clearReq = 1'b0;
        busy_cycles = 0;
        for (int it = 0; it < 20; it++) begin
            read1     = 3'(busy_cycles);
            read2     = 3'(busy_cycles - 1);
            isWrite   = (busy_cycles == 1);
            wrMode    = 2'd0;
            writeReg  = 3'd7;
            writeData = 8'h55;
            clearReq  = (busy_cycles == 3);
            cycle();
            if (!s_busy[0]) break;
            chk($sformatf("sweep%0d_unswept", busy_cycles), 32'(s_acc1[0]), 'hAA);
            if (busy_cycles > 0)
                chk($sformatf("sweep%0d_swept", busy_cycles), 32'(s_acc2[0]), 0);
            busy_cycles++;
        end
        chk("sweep_busy_cycles", busy_cycles, 8);
        idle_inputs();
        read1 = 3'd7;
        read2 = 3'd0;
        cycle();
        chk("sweep_dropped_write", 32'(s_acc1[0]), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            read1     = 3'($urandom_range(0, 7));
            read2     = 3'($urandom_range(0, 7));
            writeReg  = 3'($urandom_range(0, 7));
            isWrite   = ($urandom_range(0, 9) < 7);
            wrMode    = 2'($urandom_range(0, 3));
            writeData = 8'($urandom);
            clearReq  = ($urandom_range(0, 39) == 0);
            cycle();
        end

        // Reset in the middle of a sweep
        idle_inputs();
        repeat (10) cycle();
        for (int a = 0; a < 8; a++) begin
            isWrite = 1'b1; wrMode = 2'd0; writeReg = 3'(a); writeData = 8'(8'h80 | a);
            cycle();
        end
        idle_inputs();
        clearReq = 1'b1;
        cycle();
        clearReq = 1'b0;
        repeat (3) cycle();
        #2;
        RST_N = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("midrst_busy[%0d]", k), 32'(busy_o[k]), 0);
        check_all_zero("midrst");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        read1 = 3'd4;
        read2 = 3'd6;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
